cpu_datapath: RTL and testbench

- 32-bit single-bus datapath of a RISC CPU. All micro-operation control signals come from outside (testbench or separate control unit).
- Contains the register file, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, ALU, select-and-encode logic, CON flip-flop, IN/OUT ports and a 512x32 word-addressed RAM.
- Testbenches drive microsteps such as T0..T5 of an instruction directly.

---
 rtl/cpu_datapath.sv | 152 +++++++++++++++
 tb/tb_cpu_datapath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus RISC datapath. Every micro-operation
// control is an input, so a bench or an external control unit can sequence
// instruction steps (T0..Tn) directly.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   *out                bus drive selects (priority order in the bus mux)
//   *in                 register load enables
//   AND..NOT            one-hot ALU op select (A = Y, B = bus, result -> Z)
//   Gra/Grb/Grc         pick IR field Ra/Rb/Rc as the register index
//   Rin/Rout/BAout      write / read / base-address-read that register
//   Read, read_mem      MDR takes RAM data instead of the bus
//   write_mem           RAM[MAR] <= MDR
//   IncPC               PCin increments PC; MARin takes the current PC
//   CONin, CON_RESET    evaluate / clear the branch condition flop (con_ff)
//   PCSave              R15 <= PC
//   IN_unit_input       input port, sampled every cycle
//   OUT_unit_output     output port register
//
// RAM starts as all zeros; contents are loaded through write_mem.
module cpu_datapath #(
  parameter int MEM_DEPTH = 512,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HIout, LOout, Zhighout, Zlowout, PCout, IRout,
  input  logic              MDRout, INout, Cout, Yout, MARout,
  input  logic              Read,
  input  logic              IncPC,
  input  logic              AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL,
  input  logic              ROR, ROL, NEG, NOT,
  input  logic              Gra, Grb, Grc,
  input  logic              Rin, Rout, BAout,
  input  logic              HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
  input  logic              CONin, OUT_Portin,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic              CON_RESET,
  input  logic              PCSave,
  input  logic [DATA_W-1:0] IN_unit_input,
  output logic [DATA_W-1:0] OUT_unit_output
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0]   regs [16];
  logic [DATA_W-1:0]   pc, ir, mdr, y, hi, lo, in_reg, out_reg;
  logic [AW-1:0]       mar;
  logic [2*DATA_W-1:0] z;
  logic                con_ff;

  logic [DATA_W-1:0] ram [MEM_DEPTH] = '{default: '0};

  // Select/encode: OR of the gated IR register fields
  logic [3:0] sel;
  assign sel = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);

  logic [DATA_W-1:0] c_ext;
  assign c_ext = {{(DATA_W-19){ir[18]}}, ir[18:0]};

  // Bus: priority mux, first asserted driver wins
  logic [DATA_W-1:0] bus;
  always_comb begin
    bus = '0;
    if (Rout | BAout)  bus = (BAout && sel == 4'd0) ? '0 : regs[sel];
    else if (HIout)    bus = hi;
    else if (LOout)    bus = lo;
    else if (Zhighout) bus = z[2*DATA_W-1:DATA_W];
    else if (Zlowout)  bus = z[DATA_W-1:0];
    else if (PCout)    bus = pc;
    else if (MDRout)   bus = mdr;
    else if (INout)    bus = in_reg;
    else if (Cout)     bus = c_ext;
    else if (Yout)     bus = y;
    else if (MARout)   bus = {{(DATA_W-AW){1'b0}}, mar};
    else if (IRout)    bus = ir;
  end

  // ALU. Word ops sign-extend into the high half; shifts and rotates
  // leave the high half zero.
  logic [4:0]          sh;
  logic [2*DATA_W-1:0] prod, rr, rl, alu;
  logic [DATA_W-1:0]   word;
  assign sh   = bus[4:0];
  assign prod = $signed({{DATA_W{y[DATA_W-1]}}, y}) * $signed({{DATA_W{bus[DATA_W-1]}}, bus});
  assign rr   = {y, y} >> sh;
  assign rl   = {y, y} << sh;

  always_comb begin
    alu  = '0;
    word = '0;
    if      (ADD) word = y + bus;
    else if (SUB) word = y - bus;
    else if (AND) word = y & bus;
    else if (OR)  word = y | bus;
    else if (NEG) word = -bus;
    else if (NOT) word = ~bus;
    if (ADD | SUB | AND | OR | NEG | NOT)
      alu = {{DATA_W{word[DATA_W-1]}}, word};
    else if (MUL)
      alu = prod;
    else if (DIV) begin
      if (bus != '0)
        alu = {DATA_W'($signed(y) % $signed(bus)), DATA_W'($signed(y) / $signed(bus))};
    end
    else if (SHR)  alu = {{DATA_W{1'b0}}, y >> sh};
    else if (SHRA) alu = {{DATA_W{1'b0}}, DATA_W'($signed(y) >>> sh)};
    else if (SHL)  alu = {{DATA_W{1'b0}}, y << sh};
    else if (ROR)  alu = {{DATA_W{1'b0}}, rr[DATA_W-1:0]};
    else if (ROL)  alu = {{DATA_W{1'b0}}, rl[2*DATA_W-1:DATA_W]};
  end

  logic cond;
  always_comb begin
    case (ir[20:19])
      2'b00:   cond = (bus == '0);
      2'b01:   cond = (bus != '0);
      2'b10:   cond = ~bus[DATA_W-1];
      default: cond = bus[DATA_W-1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      pc <= '0; ir <= '0; mar <= '0; mdr <= '0; y <= '0; z <= '0;
      hi <= '0; lo <= '0; con_ff <= 1'b0; in_reg <= '0; out_reg <= '0;
    end else begin
      in_reg <= IN_unit_input;
      // Rin is assigned after PCSave so it wins a same-cycle write to R15
      if (PCSave) regs[15] <= pc;
      if (Rin)    regs[sel] <= bus;
      if (PCin)   pc <= IncPC ? pc + 1'b1 : bus;
      if (MARin)  mar <= IncPC ? pc[AW-1:0] : bus[AW-1:0];
      if (MDRin)  mdr <= (Read | read_mem) ? ram[mar] : bus;
      if (IRin)   ir <= bus;
      if (Yin)    y <= bus;
      if (HIin)   hi <= bus;
      if (LOin)   lo <= bus;
      if (Zin)    z <= alu;
      if (OUT_Portin) out_reg <= bus;
      if (CON_RESET)  con_ff <= 1'b0;
      else if (CONin) con_ff <= cond;
    end
  end

  always_ff @(posedge clk) begin
    if (write_mem) ram[mar] <= mdr;
  end

  assign OUT_unit_output = out_reg;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed bench for cpu_datapath. ALU ops run from a
// vector table; fetch, ldi, ori, CON, ports and PCSave run as microstep
// sequences. Operands enter through the IN port.
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic reset;
  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic Read, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic read_mem, write_mem, CON_RESET, PCSave;
  logic [31:0] IN_unit_input, OUT_unit_output;

  int checks = 0;
  int errors = 0;

  cpu_datapath dut (
    .clk(clk), .reset(reset),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
    .Yout(Yout), .MARout(MARout), .Read(Read), .IncPC(IncPC),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin),
    .read_mem(read_mem), .write_mem(write_mem), .CON_RESET(CON_RESET),
    .PCSave(PCSave), .IN_unit_input(IN_unit_input), .OUT_unit_output(OUT_unit_output)
  );

  always #5 clk = ~clk;

  localparam int OP_AND = 0, OP_OR = 1, OP_ADD = 2, OP_SUB = 3, OP_MUL = 4,
                 OP_DIV = 5, OP_SHR = 6, OP_SHRA = 7, OP_SHL = 8, OP_ROR = 9,
                 OP_ROL = 10, OP_NEG = 11, OP_NOT = 12, OP_NONE = 13;

  typedef struct {
    string       name;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          full;   // compare all 64 bits of Z, else only Zlow
  } alu_vec_t;

  alu_vec_t vecs [18];

  task automatic clear_ctl();
    {HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout} = '0;
    {Read, IncPC, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;
    {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin} = '0;
    {read_mem, write_mem, CON_RESET, PCSave} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  // IN register samples the port every edge, so give it one cycle first
  task automatic put_in(input logic [31:0] v);
    IN_unit_input = v;
    tick();
  endtask

  task automatic set_op(input int op);
    case (op)
      OP_AND:  AND = 1'b1;
      OP_OR:   OR = 1'b1;
      OP_ADD:  ADD = 1'b1;
      OP_SUB:  SUB = 1'b1;
      OP_MUL:  MUL = 1'b1;
      OP_DIV:  DIV = 1'b1;
      OP_SHR:  SHR = 1'b1;
      OP_SHRA: SHRA = 1'b1;
      OP_SHL:  SHL = 1'b1;
      OP_ROR:  ROR = 1'b1;
      OP_ROL:  ROL = 1'b1;
      OP_NEG:  NEG = 1'b1;
      OP_NOT:  NOT = 1'b1;
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"add",      OP_ADD,  32'd5,        32'd7,        64'h00000000_0000000C, 1'b1};
    vecs[1]  = '{"sub_neg",  OP_SUB,  32'd5,        32'd7,        64'hFFFFFFFF_FFFFFFFE, 1'b1};
    vecs[2]  = '{"and",      OP_AND,  32'h0000F0F0, 32'h0000FF00, 64'h00000000_0000F000, 1'b1};
    vecs[3]  = '{"or",       OP_OR,   32'h000000F0, 32'h0000000F, 64'h00000000_000000FF, 1'b1};
    vecs[4]  = '{"mul",      OP_MUL,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b1};
    vecs[5]  = '{"div",      OP_DIV,  32'd17,       32'd5,        64'h00000002_00000003, 1'b1};
    vecs[6]  = '{"div_neg",  OP_DIV,  32'hFFFFFFEF, 32'd5,        64'hFFFFFFFE_FFFFFFFD, 1'b1};
    vecs[7]  = '{"div_zero", OP_DIV,  32'd17,       32'd0,        64'h0,                 1'b1};
    vecs[8]  = '{"shr",      OP_SHR,  32'h80000000, 32'd4,        64'h08000000,          1'b0};
    vecs[9]  = '{"shra",     OP_SHRA, 32'h80000000, 32'd4,        64'hF8000000,          1'b0};
    vecs[10] = '{"shl_amt5", OP_SHL,  32'd1,        32'd36,       64'h00000010,          1'b0};
    vecs[11] = '{"ror",      OP_ROR,  32'd1,        32'd1,        64'h80000000,          1'b0};
    vecs[12] = '{"rol",      OP_ROL,  32'h80000001, 32'd4,        64'h00000018,          1'b0};
    vecs[13] = '{"neg",      OP_NEG,  32'd0,        32'd5,        64'hFFFFFFFF_FFFFFFFB, 1'b1};
    vecs[14] = '{"not",      OP_NOT,  32'd0,        32'd0,        64'hFFFFFFFF_FFFFFFFF, 1'b1};
    vecs[15] = '{"no_op",    OP_NONE, 32'd5,        32'd7,        64'h0,                 1'b1};
    vecs[16] = '{"mul_big",  OP_MUL,  32'h80000000, 32'd2,        64'hFFFFFFFF_00000000, 1'b1};
    vecs[17] = '{"add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd1,        64'h0,                 1'b1};

    clear_ctl();
    IN_unit_input = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_pc",  dut.pc, 0);
    chk("rst_mar", dut.mar, 0);
    chk("rst_z",   dut.z, 0);
    chk("rst_out", OUT_unit_output, 0);
    chk("rst_con", dut.con_ff, 0);

    // Store the instruction (Ra=R2, Rb=R0, C=0x55) at RAM[0]
    put_in(32'h0);        INout = 1; MARin = 1; tick();
    put_in(32'h01000055); INout = 1; MDRin = 1; tick();
    write_mem = 1; tick();
    // R0 = all ones (IR is zero, so Ra selects R0)
    put_in(32'hFFFFFFFF); INout = 1; Gra = 1; Rin = 1; tick();
    chk("r0_load", dut.regs[0], 32'hFFFFFFFF);

    // Fetch
    PCin = 1; IncPC = 1; MARin = 1; tick();
    chk("fetch_pc",  dut.pc, 1);
    chk("fetch_mar", dut.mar, 0);
    Read = 1; MDRin = 1; tick();
    chk("fetch_mdr", dut.mdr, 32'h01000055);
    MDRout = 1; IRin = 1; tick();
    chk("fetch_ir", dut.ir, 32'h01000055);

    // ldi R2, 0x55(R0)
    Grb = 1; BAout = 1; Yin = 1; tick();
    chk("ldi_y_r0_zero", dut.y, 0);
    Cout = 1; ADD = 1; Zin = 1; tick();
    Zlowout = 1; Gra = 1; Rin = 1; tick();
    chk("ldi_r2", dut.regs[2], 32'h55);

    // Second fetch through read_mem, RAM[1] is zero
    PCin = 1; IncPC = 1; MARin = 1; tick();
    chk("fetch2_pc_mar", {dut.pc, 23'd0, dut.mar}, {32'd2, 32'd1});
    read_mem = 1; MDRin = 1; tick();
    chk("read_mem_mdr", dut.mdr, 0);

    // ori R4, R3, 0x00F with R3 = 0x0F0
    put_in(32'h0218000F); INout = 1; IRin = 1; tick();
    put_in(32'h000000F0); INout = 1; Grb = 1; Rin = 1; tick();
    chk("ori_r3", dut.regs[3], 32'hF0);
    Grb = 1; Rout = 1; Yin = 1; tick();
    Cout = 1; OR = 1; Zin = 1; tick();
    Zlowout = 1; Gra = 1; Rin = 1; tick();
    chk("ori_r4", dut.regs[4], 32'hFF);

    // C sign extension from IR[18]
    put_in(32'h00040000); INout = 1; IRin = 1; tick();
    Cout = 1; Yin = 1; tick();
    chk("c_sext", dut.y, 32'hFFFC0000);

    // ALU table
    foreach (vecs[i]) begin
      put_in(vecs[i].a); INout = 1; Yin = 1; tick();
      put_in(vecs[i].b); INout = 1; set_op(vecs[i].op); Zin = 1; tick();
      chk(vecs[i].name, vecs[i].full ? dut.z : {32'h0, dut.z[31:0]},
          vecs[i].full ? vecs[i].exp : {32'h0, vecs[i].exp[31:0]});
    end

    // HI/LO from Z halves
    put_in(32'hFFFFFFFD); INout = 1; Yin = 1; tick();
    put_in(32'd7);        INout = 1; MUL = 1; Zin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    Zlowout = 1; LOin = 1; tick();
    chk("hi_lo", {dut.hi, dut.lo}, 64'hFFFFFFFF_FFFFFFEB);

    // CON flip-flop
    put_in(32'h00080000); INout = 1; IRin = 1; tick();
    put_in(32'd5);        INout = 1; CONin = 1; tick();
    chk("con_ne", dut.con_ff, 1);
    CON_RESET = 1; tick();
    chk("con_reset", dut.con_ff, 0);
    put_in(32'h00180000); INout = 1; IRin = 1; tick();
    put_in(32'hFFFFFFFF); INout = 1; CONin = 1; tick();
    chk("con_lt", dut.con_ff, 1);
    put_in(32'h00100000); INout = 1; IRin = 1; tick();
    put_in(32'hFFFFFFFF); INout = 1; CONin = 1; tick();
    chk("con_ge_false", dut.con_ff, 0);
    put_in(32'h00000000); INout = 1; IRin = 1; tick();
    CONin = 1; tick();
    chk("con_eq", dut.con_ff, 1);
    CONin = 1; CON_RESET = 1; tick();
    chk("con_reset_prio", dut.con_ff, 0);

    // Ports
    put_in(32'h0000ABCD); INout = 1; OUT_Portin = 1; tick();
    chk("out_port", OUT_unit_output, 32'hABCD);
    put_in(32'h00001234); INout = 1; Yin = 1; tick();
    chk("in_port_y", dut.y, 32'h1234);

    // MAR is 9 bits, zero-extended onto the bus
    put_in(32'hFFFFFFFF); INout = 1; MARin = 1; tick();
    MARout = 1; Yin = 1; tick();
    chk("mar_zext", dut.y, 32'h000001FF);

    // PCSave, then Rin to R15 in the same cycle wins
    PCSave = 1; tick();
    chk("pcsave", dut.regs[15], 2);
    put_in(32'h07800000); INout = 1; IRin = 1; tick();
    put_in(32'h00000077); INout = 1; Gra = 1; Rin = 1; PCSave = 1; tick();
    chk("rin_over_pcsave", dut.regs[15], 32'h77);

    // Register drive beats PCout
    Gra = 1; Rout = 1; PCout = 1; Yin = 1; tick();
    chk("bus_priority", dut.y, 32'h77);

    // Reset clears state but not RAM
    reset = 1; tick();
    reset = 0;
    chk("rst2_r2_ir", {dut.regs[2], dut.ir}, 0);
    chk("rst2_y_out", {dut.y, OUT_unit_output}, 0);
    Read = 1; MDRin = 1; tick();
    chk("ram_keeps", dut.mdr, 32'h01000055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
